led_scan_ctrl: RTL
==================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
  N_DIG, 8, number of multiplexed digits (index width 3)
  BLANK_CYC, 16, CLK cycles of anode blanking at each digit change
  PWM_BITS, 4, brightness resolution
REQ-002 SHALL have ports, one per line, with clock and reset first:
  CLK  in  1  system clock (100 MHz)
  CLR  in  1  asynchronous, active-high reset
  CE_I  in  1  one-cycle scan tick from the external prescaler (500 Hz)
  EN  in  1  scan enable
  WE  in  1  digit-register write strobe
  WADDR  in  3  digit index to write
  WDATA  in  8  segment pattern, active-high, bit7 = DP
  BRIGHT  in  PWM_BITS  brightness duty (0 = off, 15 = 15/16)
  AN  out  N_DIG  anode drive, active-low, at most one bit low
  SEG  out  8  segment drive, active-low
  FRAME_O  out  1  one-cycle pulse at the start of each full scan frame
  BUSY  out  1  high while state != IDLE

Function
REQ-003 SHALL hold an N_DIG x 8 digit register file. WE writes WDATA to entry WADDR on the same CLK edge, in any state.
REQ-004 SHALL implement FSM states IDLE, BLANK, SHOW.
REQ-005 IDLE: AN = all 1, SEG = all 1. On EN=1 and CE_I=1, SHALL move to BLANK.
REQ-006 BLANK: AN = all 1. A down-counter SHALL be loaded with BLANK_CYC-1 on entry. On entry, digit index SHALL advance modulo N_DIG, wrapping 7 -> 0. When the counter reaches 0, SHALL latch the segment register for the new index and move to SHOW. Blanking therefore lasts exactly BLANK_CYC cycles.
REQ-007 Latch bypass: if WE targets the index being latched in the same cycle, SHALL latch WDATA.
REQ-008 SHOW: SEG = ~latched pattern. A free-running PWM_BITS counter SHALL run from 0 on SHOW entry. AN[index] SHALL be 0 only while pwm_cnt < BRIGHT; all other AN bits SHALL stay 1.
REQ-009 SHOW: CE_I=1 SHALL cause a move to BLANK (next digit). CE_I during BLANK SHALL be ignored, not queued.
REQ-010 FRAME_O SHALL pulse for one cycle in the cycle the index wraps from N_DIG-1 to 0. This includes the first advance after reset.
REQ-011 EN=0 in BLANK or SHOW SHALL force IDLE on the next edge, with AN = all 1 from that edge. The index SHALL be retained. EN=0 has priority over a simultaneous CE_I.
REQ-012 BRIGHT changes SHALL take effect on the next CLK cycle, with no resynchronisation. BRIGHT=0 SHALL keep all anodes off in SHOW.
REQ-013 All outputs SHALL be registered. AN and SEG SHALL never show two low anode bits in any cycle, including across BLANK/SHOW transitions.

Reset
REQ-014 CLR=1 SHALL asynchronously force the following:
  state = IDLE
  digit index = N_DIG-1, so the first digit shown is 0
  blank counter = 0, pwm counter = 0
  AN = all 1, SEG = all 1, FRAME_O = 0, BUSY = 0
  digit register file = 8'h00
REQ-015 CLR asserted mid-SHOW or mid-BLANK SHALL blank the display immediately, without waiting for a CLK edge. Operation SHALL resume from IDLE after CLR deasserts.

Structure
REQ-016 A shared package led_pkg SHALL hold the following:
  N_DIG, BLANK_CYC and PWM_BITS defaults
  the FSM state enum (IDLE, BLANK, SHOW)
  the all-off constants for AN and SEG
REQ-017 SHALL be one module with no sub-modules. The scan tick SHALL come from the existing external prescaler via CE_I.

Verification
REQ-018 Reset/first frame: CLR pulse, then EN=1 and a CE_I pulse. Required response:
  AN = 8'hFF for 16 cycles
  FRAME_O = 1 in the CE_I+1 cycle
  then AN = 8'hFE with SEG = ~reg[0]
REQ-019 Full scan: write reg[i] = 8'h01<<i, BRIGHT=15, 8 CE_I pulses 2000 cycles apart. Required response:
  AN steps FE, FD, FB ... 7F
  SEG = ~(8'h01<<i) in each slot
  exactly one FRAME_O per 8 ticks
REQ-020 PWM: BRIGHT=4 in SHOW. AN[idx] SHALL be low for 4 of every 16 cycles. BRIGHT=0 SHALL give AN = 8'hFF throughout.
REQ-021 Bypass and priority:
  WE to the next index on the final BLANK cycle, WDATA=8'hA5: SEG SHALL show 8'h5A
  EN=0 together with CE_I: SHALL go IDLE, AN = 8'hFF next cycle
REQ-022 Ignored tick and async reset:
  CE_I during BLANK: index SHALL advance only once
  CLR raised mid-SHOW between CLK edges: AN = 8'hFF before the next edge

Source files
------------

// File: rtl/led_pkg.sv
// Shared defaults, FSM state type and blanked-output constants for the LED scan controller.
package led_pkg;

    localparam int N_DIG_DEF     = 8;
    localparam int BLANK_CYC_DEF = 16;
    localparam int PWM_BITS_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Both drives are active-low, so all ones means dark.
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/led_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-digit blanking gap, then PWM-dimmed anode drive.
// All outputs registered; a scan tick during blanking is dropped, EN=0 returns to IDLE.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int N_DIG     = N_DIG_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF,
    parameter int PWM_BITS  = PWM_BITS_DEF
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE_I,
    input  logic                EN,
    input  logic                WE,
    input  logic [2:0]          WADDR,
    input  logic [7:0]          WDATA,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic [N_DIG-1:0]    AN,
    output logic [7:0]          SEG,
    output logic                FRAME_O,
    output logic                BUSY
);

    localparam int                  BW         = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0]       BLANK_LOAD = BW'(BLANK_CYC - 1);
    localparam logic [BW-1:0]       BLANK_ONE  = BW'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
    localparam logic [2:0]          LAST_IDX   = 3'(N_DIG - 1);
    localparam logic [N_DIG-1:0]    AN_DARK    = AN_OFF[N_DIG-1:0];

    scan_state_t         state;
    logic [2:0]          idx;
    logic [2:0]          idx_nxt;
    logic [BW-1:0]       blank_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_nxt;
    logic [7:0]          dig_reg [N_DIG];
    logic [7:0]          lat_pat;

    function automatic logic [N_DIG-1:0] an_drive(input logic [2:0] i);
        an_drive    = AN_DARK;
        an_drive[i] = 1'b0;
    endfunction

    assign idx_nxt = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    assign pwm_nxt = pwm_cnt + PWM_ONE;
    // A write landing on the digit being latched wins over the stored value.
    assign lat_pat = (WE && (WADDR == idx)) ? WDATA : dig_reg[idx];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < N_DIG; i++) begin
                dig_reg[i] <= 8'h00;
            end
        end else if (WE) begin
            dig_reg[WADDR] <= WDATA;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            idx       <= LAST_IDX;
            blank_cnt <= '0;
            pwm_cnt   <= '0;
            AN        <= AN_DARK;
            SEG       <= SEG_OFF;
            FRAME_O   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            FRAME_O <= 1'b0;
            case (state)
                IDLE: begin
                    AN  <= AN_DARK;
                    SEG <= SEG_OFF;
                    if (EN && CE_I) begin
                        state     <= BLANK;
                        BUSY      <= 1'b1;
                        idx       <= idx_nxt;
                        blank_cnt <= BLANK_LOAD;
                        FRAME_O   <= (idx == LAST_IDX);
                    end
                end
                BLANK: begin
                    if (!EN) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        AN    <= AN_DARK;
                        SEG   <= SEG_OFF;
                    end else if (blank_cnt == '0) begin
                        state   <= SHOW;
                        pwm_cnt <= '0;
                        SEG     <= ~lat_pat;
                        AN      <= (BRIGHT != '0) ? an_drive(idx) : AN_DARK;
                    end else begin
                        blank_cnt <= blank_cnt - BLANK_ONE;
                    end
                end
                SHOW: begin
                    if (!EN) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        AN    <= AN_DARK;
                        SEG   <= SEG_OFF;
                    end else if (CE_I) begin
                        // Anodes go dark on this same edge, so no two digits ever overlap.
                        state     <= BLANK;
                        idx       <= idx_nxt;
                        blank_cnt <= BLANK_LOAD;
                        FRAME_O   <= (idx == LAST_IDX);
                        AN        <= AN_DARK;
                        SEG       <= SEG_OFF;
                    end else begin
                        pwm_cnt <= pwm_nxt;
                        AN      <= (pwm_nxt < BRIGHT) ? an_drive(idx) : AN_DARK;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    AN    <= AN_DARK;
                    SEG   <= SEG_OFF;
                end
            endcase
        end
    end

endmodule
